// File: rtl/step_dir_generator_if.sv
// step_dir_generator_if: command and step/dir output bundle; step_count exists only with STEPGEN_COUNT_EN
interface step_dir_generator_if #(
    parameter int count_bits  = 32,
    parameter int period_bits = 32
);
    logic                   start;
    logic                   abort;
    logic                   dir_in;
    logic [count_bits-1:0]  steps;
    logic [period_bits-1:0] period;
    logic                   step;
    logic                   dir;
    logic                   busy;
    logic                   done;
`ifdef STEPGEN_COUNT_EN
    logic [count_bits-1:0]  step_count;
    modport master (output start, abort, dir_in, steps, period, input step, dir, busy, done, step_count);
    modport slave  (input start, abort, dir_in, steps, period, output step, dir, busy, done, step_count);
`else
    modport master (output start, abort, dir_in, steps, period, input step, dir, busy, done);
    modport slave  (input start, abort, dir_in, steps, period, output step, dir, busy, done);
`endif
endinterface

// File: rtl/step_dir_generator.sv
// step_dir_generator: step/dir pulse-train generator; define STEPGEN_COUNT_EN to add the signed step_count position counter
module step_dir_generator #(
    parameter int count_bits  = 32,
    parameter int period_bits = 32,
    parameter int pulse_width = 8,
    parameter int dir_setup   = 4
) (
    input logic                 clk,
    input logic                 resetn,
    step_dir_generator_if.slave bus
);
    localparam int tw = period_bits + 1;
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;
    state_t                state, nxt;
    logic [tw-1:0]         tmr, gap_q, eff;
    logic [count_bits-1:0] rem;
    logic                  dir_q, done_q, abort_q, accept, tmr_zero, step_o, busy_o, pulse_start;
    assign accept      = state == IDLE && bus.start && bus.steps != '0;
    assign tmr_zero    = tmr == '0;
    assign pulse_start = nxt == PULSE && state != PULSE;
    assign eff         = {1'b0, bus.period} > tw'(2 * pulse_width) ? {1'b0, bus.period} : tw'(2 * pulse_width);
    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt;
    end
    // next state; an abort seen during a pulse is remembered so the pulse still runs full width
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? SETUP : IDLE;
            SETUP:   nxt = bus.abort ? IDLE : tmr_zero ? PULSE : SETUP;
            PULSE:   nxt = !tmr_zero ? PULSE : (abort_q || bus.abort) ? IDLE : GAP;
            GAP:     nxt = bus.abort ? IDLE : !tmr_zero ? GAP : rem != '0 ? PULSE : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // outputs decoded from state so step drops the instant reset asserts
    always_comb begin
        step_o = state == PULSE;
        busy_o = state != IDLE;
    end
    assign bus.step = step_o;
    assign bus.busy = busy_o;
    assign bus.dir  = dir_q;
    assign bus.done = done_q;
    // phase timer, counts down the remaining cycles of SETUP, PULSE or GAP
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          tmr <= '0;
        else if (accept)                      tmr <= tw'(dir_setup - 1);
        else if (pulse_start)                 tmr <= tw'(pulse_width - 1);
        else if (state == PULSE && nxt == GAP) tmr <= gap_q;
        else if (!tmr_zero)                   tmr <= tmr - tw'(1);
    end
    // move parameters latched on an accepted start; the gap reload is derived from the effective period
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q <= 1'b0;
            gap_q <= '0;
            rem   <= '0;
        end else if (accept) begin
            dir_q <= bus.dir_in;
            gap_q <= eff - tw'(pulse_width + 1);
            rem   <= bus.steps;
        end else if (state == PULSE && nxt != PULSE) begin
            rem   <= rem - count_bits'(1);
        end
    end
    // completion pulse and pending abort
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= state == IDLE ? bus.start && bus.steps == '0 : nxt == IDLE;
            abort_q <= state == PULSE && nxt == PULSE && (abort_q || bus.abort);
        end
    end
`ifdef STEPGEN_COUNT_EN
    logic [count_bits-1:0] pos;
    // signed position, moved on every step rising edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          pos <= '0;
        else if (pulse_start) pos <= dir_q ? pos + count_bits'(1) : pos - count_bits'(1);
    end
    assign bus.step_count = pos;
`endif
endmodule

// File: tb/tb_step_dir_generator.sv
// tb_step_dir_generator: directed and random moves checked against an arithmetic timing model
module tb_step_dir_generator;
    localparam int PW = 8;
    localparam int SU = 4;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rises[$];
    int   widths[$];
    int   dones[$];
    int   busy_cnt = 0;
    int   rise_at = 0;
    logic step_prev = 1'b0;
    int   pos_m = 0;
    bit   dir_m = 1'b0;

    step_dir_generator_if bus ();
    step_dir_generator dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: edge numbers of step rises, pulse widths, done pulses and busy cycles
    always @(negedge clk) begin
        if (bus.step === 1'b1 && step_prev !== 1'b1) begin
            rises.push_back(cyc);
            rise_at = cyc;
        end
        if (bus.step !== 1'b1 && step_prev === 1'b1) widths.push_back(cyc - rise_at);
        if (bus.done === 1'b1) dones.push_back(cyc);
        if (bus.busy === 1'b1) busy_cnt++;
        step_prev = bus.step;
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // a: relative edge at which abort is sampled (0 = together with start, <0 = none)
    // rs: relative edge at which a conflicting second start is sampled (<0 = none)
    task automatic run_move(int n, int per, bit d, int a, int rs);
        int eff, nr, dn, t0, u, v, rel;
        eff = per > 2 * PW ? per : 2 * PW;
        nr  = n;
        dn  = n == 0 ? 0 : SU + n * eff;
        if (a > 0 && n != 0 && a - 1 < dn) begin
            u = a - 1;
            if (u < SU) begin
                nr = 0;
                dn = a;
            end else begin
                v  = u - SU;
                nr = v / eff + 1;
                dn = (v % eff < PW) ? SU + (nr - 1) * eff + PW : a;
            end
        end
        rises.delete();
        widths.delete();
        dones.delete();
        busy_cnt   = 0;
        bus.start  = 1'b1;
        bus.steps  = n;
        bus.period = per;
        bus.dir_in = d;
        bus.abort  = (a == 0);
        t0 = cyc + 1;
        for (int i = 0; i < dn + 4; i++) begin
            @(negedge clk);
            rel = cyc - t0 + 1;
            bus.start = (rel == rs);
            if (bus.start) begin
                bus.steps  = n + 5;
                bus.period = per + 30;
                bus.dir_in = !d;
            end else begin
                bus.steps  = $urandom;
                bus.period = $urandom;
                bus.dir_in = 1'($urandom);
            end
            bus.abort = (rel == a);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (n != 0) dir_m = d;
        check("n_rises", rises.size(), nr);
        foreach (rises[k]) check("rise_at", rises[k] - t0, SU + k * eff);
        check("n_pulses", widths.size(), nr);
        foreach (widths[k]) check("pulse_width", widths[k], PW);
        check("n_done", dones.size(), 1);
        if (dones.size() > 0) check("done_at", dones[0] - t0, dn);
        check("busy_cycles", busy_cnt, dn);
        check("dir", bus.dir, dir_m);
`ifdef STEPGEN_COUNT_EN
        pos_m += d ? nr : -nr;
        check("step_count", bus.step_count, 32'(pos_m));
`endif
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.dir_in = 1'b0;
        bus.steps  = '0;
        bus.period = '0;
        repeat (2) @(negedge clk);
        check("reset_step", bus.step, 0);
        check("reset_dir", bus.dir, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
`ifdef STEPGEN_COUNT_EN
        check("reset_step_count", bus.step_count, 0);
`endif
        resetn = 1'b1;
        run_move(3, 20, 1'b1, -1, -1);
        run_move(2, 5, 1'b1, -1, -1);
        run_move(10, 20, 1'b1, 27, -1);
        run_move(0, 20, 1'b0, -1, -1);
        run_move(4, 30, 1'b0, -1, 10);
        run_move(3, 20, 1'b1, 2, -1);
        run_move(3, 20, 1'b1, 15, -1);
        run_move(2, 17, 1'b0, 0, -1);
        for (int i = 0; i < 8; i++)
            run_move($urandom_range(0, 4), $urandom_range(0, 40), 1'($urandom),
                     $urandom_range(0, 2) == 0 ? $urandom_range(1, 120) : -1, -1);
        bus.start  = 1'b1;
        bus.steps  = 5;
        bus.period = 20;
        bus.dir_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_step", bus.step, 1);
        #2;
        dones.delete();
        resetn = 1'b0;
        #1;
        check("async_reset_step", bus.step, 0);
        check("async_reset_busy", bus.busy, 0);
        check("async_reset_done", bus.done, 0);
        check("async_reset_dir", bus.dir, 0);
        pos_m = 0;
        dir_m = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_no_done", dones.size(), 0);
`ifdef STEPGEN_COUNT_EN
        check("reset_clears_count", bus.step_count, 0);
`endif
        resetn = 1'b1;
        run_move(1, 10, 1'b0, -1, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/step_dir_generator.md
STEP_DIR_GENERATOR -- requirements
Module: step_dir_generator

Interface
REQ-001 The block SHALL have parameter count_bits, default 32, width of the step-count request and position counter.
REQ-002 The block SHALL have parameter period_bits, default 32, width of the step period in clk cycles.
REQ-003 The block SHALL have parameter pulse_width, default 8, step-high time in clk cycles, minimum 1.
REQ-004 The block SHALL have parameter dir_setup, default 4, dir-to-first-step-edge setup time in clk cycles, minimum 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock, all logic on its rising edge.
REQ-006 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port start  input  1  single-cycle move request, sampled only in IDLE.
REQ-008 The block SHALL have port abort  input  1  stop request, sampled only while busy.
REQ-009 The block SHALL have port dir_in  input  1  requested direction, latched on accepted start.
REQ-010 The block SHALL have port steps  input  count_bits  unsigned step count, latched on accepted start.
REQ-011 The block SHALL have port period  input  period_bits  clk cycles between step rising edges, latched on accepted start.
REQ-012 The block SHALL have ports step  output  1, dir  output  1, busy  output  1, done  output  1 (one-cycle completion pulse).
REQ-013 The block SHALL have port step_count  output  count_bits  signed position, present only per REQ-030.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, PULSE and GAP; busy SHALL be high in every state except IDLE.
REQ-015 When start is high in IDLE with steps != 0, the block SHALL latch steps, period and dir_in, drive dir from the latched value on the same edge, and enter SETUP.
REQ-016 When start is high in IDLE with steps == 0, the block SHALL stay in IDLE, leave step low and pulse done for one cycle on the next edge.
REQ-017 SETUP SHALL last exactly dir_setup cycles, then enter PULSE; step SHALL rise on the edge that enters PULSE.
REQ-018 PULSE SHALL hold step high for exactly pulse_width cycles, then enter GAP with step low.
REQ-019 The effective period SHALL be max(period, 2*pulse_width); consecutive step rising edges SHALL be exactly that many cycles apart.
REQ-020 On leaving PULSE, the remaining-step counter SHALL decrement by one; at the end of GAP, the block SHALL enter PULSE if the count is non-zero, or IDLE otherwise.
REQ-021 On the transition to IDLE, busy SHALL fall and done SHALL be high for exactly that one cycle.
REQ-022 Abort in SETUP SHALL return to IDLE on the next edge with done pulsed and no step edge.
REQ-023 Abort in PULSE SHALL finish the current pulse at full width (no runt pulse), then go to IDLE with done pulsed, skipping GAP.
REQ-024 Abort in GAP SHALL go to IDLE on the next edge with done pulsed.
REQ-025 The block SHALL ignore start while busy, and SHALL ignore abort in IDLE; when start and abort are both high in IDLE, start SHALL be accepted.
REQ-026 dir SHALL change only on an accepted start and SHALL hold its value in IDLE.

Reset
REQ-027 While resetn is low, the block SHALL immediately be in IDLE with step=0, dir=0, busy=0 and done=0, and all counters and latched registers SHALL be zero.
REQ-028 An assertion of resetn mid-move SHALL abandon the move; step SHALL fall asynchronously, with no done pulse.
REQ-029 After resetn deasserts, the first start SHALL be accepted on the first clk edge.

Configuration
REQ-030 With STEPGEN_COUNT_EN defined, step_count SHALL exist, reset to 0, and change by +1 (dir=1) or -1 (dir=0) on each step rising edge, wrapping modulo 2^count_bits.
REQ-031 Without STEPGEN_COUNT_EN, the step_count port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Bench: steps=3, period=20, dir_in=1, pulse_width=8, dir_setup=4 -> dir=1, step rises at cycles 4, 24 and 44 after start, each pulse 8 cycles wide; done pulses at cycle 64; step_count=3.
REQ-033 Bench: steps=2, period=5 -> effective period 16, so step rises are 16 cycles apart.
REQ-034 Bench: abort 3 cycles into the second pulse of a 10-step move -> the pulse completes at 8 cycles, done pulses, exactly 2 step edges occur, and step_count=2 (dir=1).
REQ-035 Bench: start with steps=0 -> no step edge, busy stays 0, done pulses on the next cycle.
REQ-036 Bench: resetn asserted during PULSE -> step=0 and busy=0 immediately, no done pulse; after release, start with dir_in=0 and steps=1 -> step_count=-1.
REQ-037 Bench: a second start while busy -> ignored, so the step count and latched period remain those of the first move.
